instr_fetcher: RTL

//  Consumes instruction words returned by the instruction memory (read addresses issued by

---
 rtl/common_pkg.sv | 6 +
 rtl/instr_decd_pkg.sv | 21 ++
 rtl/sync_fifo_regs.sv | 73 +++++++
 rtl/instr_fetcher.sv | 86 ++++++++
 4 files changed

// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - project-wide constants shared by all blocks
package common_pkg;

  localparam logic RESET_STATE = 1'b0;

endpackage

// File: rtl/instr_decd_pkg.sv
// rtl/instr_decd_pkg.sv - instruction word layout, opcodes and field helpers
package instr_decd_pkg;

  localparam int INSTR_L  = 32;
  localparam int OPCODE_L = 4;

  typedef enum logic [OPCODE_L-1:0] {
    OP_NOP  = 4'h0,
    OP_LOAD = 4'h1,
    OP_STOR = 4'h2,
    OP_ADD  = 4'h3,
    OP_MUL  = 4'h4,
    OP_JMP  = 4'h5,
    OP_END  = 4'hF
  } opcode_e;

  function automatic logic [OPCODE_L-1:0] opcode_of(input logic [INSTR_L-1:0] instr);
    return instr[INSTR_L-1 -: OPCODE_L];
  endfunction

endpackage

// File: rtl/sync_fifo_regs.sv
// rtl/sync_fifo_regs.sv - register-based synchronous FIFO with combinational head read
module sync_fifo_regs
  import common_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    full    = (count_q == CNT_DEPTH);
    empty   = (count_q == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    rdata = empty ? '0 : mem_q[rd_ptr_q];
    count = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst == RESET_STATE) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - buffers fetched instruction words for the decoder, stops on END
module instr_fetcher
  import instr_decd_pkg::*;
  import common_pkg::*;
#(
  parameter int                    DEPTH      = 4,
  parameter int                    INSTR_W    = INSTR_L,
  parameter int                    OPCODE_W   = OPCODE_L,
  parameter logic [OPCODE_W-1:0]   END_OPCODE = OPCODE_W'(OP_END)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               instr_vld_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               fetcher_rdy,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_out_vld,
  input  logic               decoder_rdy,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               word_acc, is_end;
  logic               fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [INSTR_W-1:0] fifo_rdata;

  sync_fifo_regs #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (instr_in),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    // rdy depends only on state and stored count, never on this cycle's inputs.
    fetcher_rdy   = (state_q == S_FETCH) & ~fifo_full;
    word_acc      = instr_vld_in & fetcher_rdy;
    is_end        = (instr_in[INSTR_W-1 -: OPCODE_W] == END_OPCODE);
    fifo_push     = word_acc & ~is_end;
    instr_out_vld = ~fifo_empty;
    instr_out     = fifo_rdata;
    fifo_pop      = instr_out_vld & decoder_rdy;
    busy          = (state_q == S_FETCH) | (state_q == S_DRAIN);
    done          = (state_q == S_DONE);
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (word_acc && is_end) state_d = S_DRAIN;
      // Leave DRAIN as soon as the buffer will be empty after this cycle's pop.
      S_DRAIN: if (fifo_count == '0 || (fifo_count == CNT_ONE && fifo_pop)) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RESET_STATE) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
